// File: rtl/soc_system_pll_pkg.sv
// Shared types and helpers for the sys/SDRAM PLL lock controller.
package soc_system_pll_pkg;

    // FSM encoding; also visible to software through state_o.
    typedef enum logic [2:0] {
        StPllRst   = 3'd0,
        StWaitLock = 3'd1,
        StStable   = 3'd2,
        StRun      = 3'd3,
        StFail     = 3'd4
    } pll_state_e;

    localparam int unsigned RETRY_W = 8;

    // Width of the shared timing counter: enough for the longest timed state.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/soc_system_pll_lock_sync.sv
// Multi-flop bit synchroniser with asynchronous active-low reset (resets to 0).
module soc_system_pll_lock_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/soc_system_pll_lock_ctrl.sv
// PLL reset/lock controller: pulses the PLL reset, waits for lock with timeout and retry,
// qualifies lock stability, then releases sys_reset_n. Runs on the PLL reference clock.
// Optional macro PLL_LOCK_CTRL_RETRY_LIMIT_EN: stop in FAIL once retries reach MAX_RETRIES.
module soc_system_pll_lock_ctrl
    import soc_system_pll_pkg::*;
#(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 50000,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned MAX_RETRIES   = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               pll_locked,
    output logic               pll_rst,
    output logic               sys_reset_n,
    output logic               lock_lost,
    input  logic               lock_lost_clr,
    output logic [RETRY_W-1:0] retry_count,
    output logic [2:0]         state_o,
    output logic               fail
);

    localparam int unsigned CNT_W = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

    // Elaboration-time sanity checks on the configuration.
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (RST_CYCLES < 1) begin : g_bad_rst
        $error("RST_CYCLES must be at least 1");
    end
    if (MAX_RETRIES < 1) begin : g_bad_retries
        $error("MAX_RETRIES must be at least 1");
    end

    pll_state_e         state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               pll_rst_q;
    logic               sys_reset_n_q;
    logic               lock_lost_q;
    logic [RETRY_W-1:0] retry_q;
    logic               fail_q;
    logic               lock_s;
    logic [RETRY_W-1:0] retry_inc;
    logic               limit_hit;

    soc_system_pll_lock_sync #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (pll_locked),
        .q       (lock_s)
    );

    // Saturating increment of the retry counter.
    assign retry_inc = (retry_q == '1) ? retry_q : retry_q + RETRY_W'(1);

`ifdef PLL_LOCK_CTRL_RETRY_LIMIT_EN
    assign limit_hit = (32'(retry_inc) >= MAX_RETRIES);
`else
    assign limit_hit = 1'b0;
`endif

    // Single FSM process; every output is a register updated alongside the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StPllRst;
            cnt_q         <= '0;
            pll_rst_q     <= 1'b1;
            sys_reset_n_q <= 1'b0;
            lock_lost_q   <= 1'b0;
            retry_q       <= '0;
            fail_q        <= 1'b0;
        end else begin
            // Clear first so a lock loss in the same cycle takes priority.
            if (lock_lost_clr) lock_lost_q <= 1'b0;
            case (state_q)
                StPllRst: begin
                    if (cnt_q == RST_LAST) begin
                        state_q   <= StWaitLock;
                        cnt_q     <= '0;
                        pll_rst_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StWaitLock: begin
                    if (lock_s) begin
                        state_q <= StStable;
                        cnt_q   <= '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        state_q   <= limit_hit ? StFail : StPllRst;
                        fail_q    <= limit_hit;
                        cnt_q     <= '0;
                        pll_rst_q <= 1'b1;
                        retry_q   <= retry_inc;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StStable: begin
                    if (!lock_s) begin
                        // Glitch restarts qualification; not counted as a retry.
                        state_q <= StWaitLock;
                        cnt_q   <= '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_q       <= StRun;
                        cnt_q         <= '0;
                        sys_reset_n_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StRun: begin
                    if (!lock_s) begin
                        state_q       <= limit_hit ? StFail : StPllRst;
                        fail_q        <= limit_hit;
                        cnt_q         <= '0;
                        pll_rst_q     <= 1'b1;
                        sys_reset_n_q <= 1'b0;
                        lock_lost_q   <= 1'b1;
                        retry_q       <= retry_inc;
                    end
                end
                StFail: begin
                    // Terminal until reset_n; outputs already held at failure values.
                    pll_rst_q     <= 1'b1;
                    sys_reset_n_q <= 1'b0;
                end
                default: begin
                    state_q       <= StPllRst;
                    cnt_q         <= '0;
                    pll_rst_q     <= 1'b1;
                    sys_reset_n_q <= 1'b0;
                end
            endcase
        end
    end

    assign pll_rst     = pll_rst_q;
    assign sys_reset_n = sys_reset_n_q;
    assign lock_lost   = lock_lost_q;
    assign retry_count = retry_q;
    assign state_o     = state_q;
    // Stays 0 unless the retry limit is compiled in.
    assign fail        = fail_q;

endmodule

// File: tb/tb_soc_system_pll_lock_ctrl.sv
// Self-checking bench for soc_system_pll_lock_ctrl (RST=4, TIMEOUT=32, STABLE=8, SYNC=2, MAX=3).
module tb_soc_system_pll_lock_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       pll_locked;
    logic       lock_lost_clr;
    logic       pll_rst;
    logic       sys_reset_n;
    logic       lock_lost;
    logic [7:0] retry_count;
    logic [2:0] state_o;
    logic       fail;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    soc_system_pll_lock_ctrl #(
        .RST_CYCLES    (4),
        .LOCK_TIMEOUT  (32),
        .STABLE_CYCLES (8),
        .SYNC_STAGES   (2),
        .MAX_RETRIES   (3)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .pll_locked    (pll_locked),
        .pll_rst       (pll_rst),
        .sys_reset_n   (sys_reset_n),
        .lock_lost     (lock_lost),
        .lock_lost_clr (lock_lost_clr),
        .retry_count   (retry_count),
        .state_o       (state_o),
        .fail          (fail)
    );

    typedef struct packed {
        logic [2:0] st;
        logic       prst;
        logic       srn;
        logic       ll;
        logic [7:0] rc;
        logic       fl;
    } exp_t;

    typedef struct {
        logic        rst_n;
        logic        locked;
        logic        clr;
        int unsigned n;
        exp_t        e;
    } vec_t;

    vec_t  vecs[$];
    exp_t  sb_exp[$];
    string sb_name[$];

    function automatic vec_t mk(input logic r, input logic l, input logic c, input int unsigned n,
                                input logic [2:0] st, input logic prst, input logic srn,
                                input logic ll, input logic [7:0] rc, input logic fl);
        vec_t v;
        v.rst_n  = r;
        v.locked = l;
        v.clr    = c;
        v.n      = n;
        v.e      = '{st: st, prst: prst, srn: srn, ll: ll, rc: rc, fl: fl};
        return v;
    endfunction

    task automatic push_exp(input exp_t e, input string name);
        sb_exp.push_back(e);
        sb_name.push_back(name);
    endtask

    // Pop the oldest expectation and compare it to the current DUT outputs.
    task automatic check_out();
        exp_t  e;
        exp_t  got;
        string name;
        if (sb_exp.size() == 0) begin
            tests++;
            failed++;
            $display("FAIL scoreboard: got empty queue, required an entry");
            return;
        end
        e    = sb_exp.pop_front();
        name = sb_name.pop_front();
        got  = {state_o, pll_rst, sys_reset_n, lock_lost, retry_count, fail};
        tests++;
        if (got !== e) begin
            failed++;
            $display("FAIL %s: got st=%0d prst=%b srn=%b ll=%b rc=%0d fail=%b, required st=%0d prst=%b srn=%b ll=%b rc=%0d fail=%b",
                     name, got.st, got.prst, got.srn, got.ll, got.rc, got.fl,
                     e.st, e.prst, e.srn, e.ll, e.rc, e.fl);
        end
    endtask

    // Bounded wait for a given state, sampled on negedges.
    task automatic wait_state(input logic [2:0] want, input int unsigned budget, input string name);
        int unsigned k = 0;
        while (state_o !== want && k < budget) begin
            @(posedge clk);
            @(negedge clk);
            k++;
        end
        tests++;
        if (state_o !== want) begin
            failed++;
            $display("FAIL %s: got state_o=%0d, required %0d within %0d cycles",
                     name, state_o, want, budget);
        end
    endtask

    initial begin
        reset_n       = 1'b0;
        pll_locked    = 1'b0;
        lock_lost_clr = 1'b0;

        // Edge counts in comments are posedges since the last reset release.
        vecs.push_back(mk(0, 0, 0,  1, 0, 1, 0, 0, 0, 0));  // reset state
        vecs.push_back(mk(1, 0, 0,  3, 0, 1, 0, 0, 0, 0));  // E3 still in PLL reset
        vecs.push_back(mk(1, 0, 0,  1, 1, 0, 0, 0, 0, 0));  // E4 wait lock
        vecs.push_back(mk(1, 0, 0, 31, 1, 0, 0, 0, 0, 0));  // E35 just before timeout
        vecs.push_back(mk(1, 0, 0,  1, 0, 1, 0, 0, 1, 0));  // E36 first retry
        vecs.push_back(mk(1, 0, 0,  4, 1, 0, 0, 0, 1, 0));  // E40
        vecs.push_back(mk(1, 0, 0, 32, 0, 1, 0, 0, 2, 0));  // E72 second retry
`ifdef PLL_LOCK_CTRL_RETRY_LIMIT_EN
        vecs.push_back(mk(1, 0, 0, 36, 4, 1, 0, 0, 3, 1));  // E108 limit -> FAIL
        vecs.push_back(mk(1, 0, 0, 36, 4, 1, 0, 0, 3, 1));  // E144 FAIL held
`else
        vecs.push_back(mk(1, 0, 0, 36, 0, 1, 0, 0, 3, 0));  // E108 third retry
        vecs.push_back(mk(1, 0, 0, 36, 0, 1, 0, 0, 4, 0));  // E144 retries past limit
`endif
        vecs.push_back(mk(0, 0, 0,  1, 0, 1, 0, 0, 0, 0));  // reset
        vecs.push_back(mk(1, 0, 0, 10, 1, 0, 0, 0, 0, 0));  // E10
        vecs.push_back(mk(1, 1, 0,  3, 2, 0, 0, 0, 0, 0));  // E13 stable
        vecs.push_back(mk(1, 1, 0,  7, 2, 0, 0, 0, 0, 0));  // E20 still qualifying
        vecs.push_back(mk(1, 1, 0,  1, 3, 0, 1, 0, 0, 0));  // E21 run
        vecs.push_back(mk(1, 0, 0,  2, 3, 0, 1, 0, 0, 0));  // E23 loss not yet seen
        vecs.push_back(mk(1, 0, 0,  1, 0, 1, 0, 1, 1, 0));  // E24 lock lost
        vecs.push_back(mk(1, 1, 0,  4, 1, 0, 0, 1, 1, 0));  // E28
        vecs.push_back(mk(1, 1, 0,  1, 2, 0, 0, 1, 1, 0));  // E29
        vecs.push_back(mk(1, 1, 0,  8, 3, 0, 1, 1, 1, 0));  // E37 run again
        vecs.push_back(mk(1, 1, 1,  1, 3, 0, 1, 0, 1, 0));  // E38 clear
        vecs.push_back(mk(1, 1, 0,  1, 3, 0, 1, 0, 1, 0));  // E39
        vecs.push_back(mk(1, 0, 0,  2, 3, 0, 1, 0, 1, 0));  // E41
        vecs.push_back(mk(1, 0, 1,  1, 0, 1, 0, 1, 2, 0));  // E42 set beats clear
        vecs.push_back(mk(1, 0, 0,  1, 0, 1, 0, 1, 2, 0));  // E43
        vecs.push_back(mk(0, 0, 0,  1, 0, 1, 0, 0, 0, 0));  // reset clears sticky/count
        vecs.push_back(mk(1, 0, 0, 10, 1, 0, 0, 0, 0, 0));  // E10
        vecs.push_back(mk(1, 1, 0,  3, 2, 0, 0, 0, 0, 0));  // E13
        vecs.push_back(mk(1, 1, 0,  2, 2, 0, 0, 0, 0, 0));  // E15
        vecs.push_back(mk(1, 0, 0,  2, 2, 0, 0, 0, 0, 0));  // E17 glitch in sync
        vecs.push_back(mk(1, 1, 0,  1, 1, 0, 0, 0, 0, 0));  // E18 back to wait
        vecs.push_back(mk(1, 1, 0,  1, 1, 0, 0, 0, 0, 0));  // E19
        vecs.push_back(mk(1, 1, 0,  1, 2, 0, 0, 0, 0, 0));  // E20 requalify
        vecs.push_back(mk(1, 1, 0,  7, 2, 0, 0, 0, 0, 0));  // E27
        vecs.push_back(mk(1, 1, 0,  1, 3, 0, 1, 0, 0, 0));  // E28 run, no retry

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            reset_n       = vecs[i].rst_n;
            pll_locked    = vecs[i].locked;
            lock_lost_clr = vecs[i].clr;
            push_exp(vecs[i].e, $sformatf("row%0d", i));
            repeat (vecs[i].n) @(posedge clk);
            @(negedge clk);
            check_out();
        end
        lock_lost_clr = 1'b0;

        // Lose lock, relock into STABLE, then reset asynchronously mid-qualification.
        pll_locked = 1'b0;
        wait_state(3'd0, 10, "loss_to_pll_rst");
        pll_locked = 1'b1;
        wait_state(3'd2, 30, "relock_to_stable");
`ifdef PLL_LOCK_CTRL_RETRY_LIMIT_EN
        push_exp('{st: 3'd2, prst: 1'b0, srn: 1'b0, ll: 1'b1, rc: 8'd1, fl: 1'b0}, "pre_midop");
`else
        push_exp('{st: 3'd2, prst: 1'b0, srn: 1'b0, ll: 1'b1, rc: 8'd1, fl: 1'b0}, "pre_midop");
`endif
        check_out();
        reset_n = 1'b0;
        push_exp('{st: 3'd0, prst: 1'b1, srn: 1'b0, ll: 1'b0, rc: 8'd0, fl: 1'b0}, "midop_async");
        #1;
        check_out();
        @(negedge clk);
        reset_n = 1'b1;
        push_exp('{st: 3'd0, prst: 1'b1, srn: 1'b0, ll: 1'b0, rc: 8'd0, fl: 1'b0}, "post_reset");
        @(posedge clk);
        @(negedge clk);
        check_out();
        wait_state(3'd3, 40, "relock_after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
